// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative RV32M/RV64M multiply/divide unit with start/busy/done
// Rev 1.0
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       op;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic             fin_stage;

    logic             in_div;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg_in;
    logic             b_neg_in;
    logic [XLEN-1:0]  a_mag_in;
    logic [XLEN-1:0]  b_mag_in;
    logic             div_ovf;
    logic             fast;
    logic [XLEN-1:0]  fast_hi;
    logic [XLEN-1:0]  fast_lo;
    logic             accept;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_shift;
    logic [XLEN:0]    div_diff;
    logic [2*XLEN-1:0] prod_neg;

    // Operand decode on the issue-cycle inputs
    always_comb begin
        in_div   = Funct3[2];
        a_signed = in_div ? ~Funct3[0] : (Funct3 != 3'b011);
        b_signed = in_div ? ~Funct3[0] : ~Funct3[1];
        a_neg_in = a_signed & rs1[XLEN-1];
        b_neg_in = b_signed & rs2[XLEN-1];
        a_mag_in = a_neg_in ? -rs1 : rs1;
        b_mag_in = b_neg_in ? -rs2 : rs2;
        div_ovf  = in_div & ~Funct3[0] & (rs1 == MOST_NEG) & (rs2 == {XLEN{1'b1}});
        fast     = in_div ? ((rs2 == '0) | div_ovf) : ((rs1 == '0) | (rs2 == '0));
        fast_hi  = '0;
        fast_lo  = '0;
        if (in_div) begin
            if (rs2 == '0) begin
                fast_hi = rs1;
                fast_lo = {XLEN{1'b1}};
            end else begin
                fast_lo = MOST_NEG;
            end
        end
        accept   = start & ((state == S_IDLE) | (state == S_DONE));
    end

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        prod_neg  = -{hi, lo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            counter   <= '0;
            op        <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            fin_stage <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            fin_stage <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op        <= Funct3;
                        a_mag     <= a_mag_in;
                        b_mag     <= b_mag_in;
                        counter   <= '0;
                        fin_stage <= 1'b0;
                        if (fast) begin
                            // Preloaded answer is already final, so sign correction must be a no-op
                            a_neg <= 1'b0;
                            b_neg <= 1'b0;
                            hi    <= fast_hi;
                            lo    <= fast_lo;
                            state <= S_FIN;
                        end else begin
                            a_neg <= a_neg_in;
                            b_neg <= b_neg_in;
                            hi    <= '0;
                            lo    <= in_div ? a_mag_in : b_mag_in;
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (op[2]) begin
                        if (!div_diff[XLEN]) begin
                            hi <= div_diff[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            hi <= div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST_ITER) begin
                        state     <= S_FIN;
                        fin_stage <= 1'b0;
                    end
                end
                S_FIN: begin
                    // Negation and output select are split over two cycles to keep the wide carry chain off the mux path
                    if (!fin_stage) begin
                        if (op[2]) begin
                            lo <= (a_neg ^ b_neg) ? -lo : lo;
                            hi <= a_neg ? -hi : hi;
                        end else if (a_neg ^ b_neg) begin
                            {hi, lo} <= prod_neg;
                        end
                        fin_stage <= 1'b1;
                    end else begin
                        result    <= ((op == 3'b000) | (op[2] & ~op[1])) ? lo : hi;
                        fin_stage <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_CALC) | (state == S_FIN);
    assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// tb_muldiv_unit : directed vectors for muldiv_unit at XLEN=32 and XLEN=64
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        start32;
    logic        start64;
    logic        flush;
    logic [2:0]  funct3;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        busy32, done32, busy64, done64;
    logic [31:0] result32;
    logic [63:0] result64;

    int vectors;
    int miscompares;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .Funct3(funct3),
        .rs1(rs1[31:0]), .rs2(rs2[31:0]), .flush(flush),
        .busy(busy32), .done(done32), .result(result32)
    );

    muldiv_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .Funct3(funct3),
        .rs1(rs1), .rs2(rs2), .flush(flush),
        .busy(busy64), .done(done64), .result(result64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input bit wide, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        if (wide) start64 = 1'b1;
        else      start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        start64 = 1'b0;
        funct3  = ~f;
        rs1     = ~a;
        rs2     = b ^ 64'h5A5A_A5A5_3C3C_C3C3;
    endtask

    // Returns edges from the accepting edge to the done cycle, and busy cycles seen before done
    task automatic wait_done(input bit wide, output int lat, output int bcnt);
        lat  = 0;
        bcnt = (wide ? busy64 : busy32) ? 1 : 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (wide ? done64 : done32) break;
            if (lat >= 200) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout waiting for done: got %0d cycles, expected done", lat);
                break;
            end
            if (wide ? busy64 : busy32) bcnt++;
        end
    endtask

    task automatic run_op(input string tag, input bit wide, input logic [2:0] f,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat, output int bcnt);
        int lat;
        start_op(wide, f, a, b);
        wait_done(wide, lat, bcnt);
        check_eq({tag, " result"}, wide ? result64 : {32'h0, result32}, exp_res);
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int bc;
        int lat;
        int cnt;
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        start32 = 1'b0;
        start64 = 1'b0;
        flush   = 1'b0;
        funct3  = 3'b000;
        rs1     = '0;
        rs2     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset busy32", {63'h0, busy32}, 64'h0);
        check_eq("reset done32", {63'h0, done32}, 64'h0);
        check_eq("reset result32", {32'h0, result32}, 64'h0);
        check_eq("reset result64", result64, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul 7*-3", 0, MUL, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 34, bc);
        @(posedge clk);
        #1;
        check_eq("done single pulse", {63'h0, done32}, 64'h0);

        run_op("mulh", 0, MULH, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 34, bc);
        run_op("mulhu", 0, MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 34, bc);
        run_op("mulhsu", 0, MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 34, bc);
        run_op("div -7/2", 0, DIV, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 34, bc);
        run_op("rem -7/2", 0, REM, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 34, bc);
        run_op("divu 100/7", 0, DIVU, 64'd100, 64'd7, 64'd14, 34, bc);
        run_op("remu 100/7", 0, REMU, 64'd100, 64'd7, 64'd2, 34, bc);

        run_op("fast divu 5/0", 0, DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF, 2, bc);
        check_eq("fast divu busy", 64'(bc), 64'd2);
        run_op("fast rem 5/0", 0, REM, 64'd5, 64'd0, 64'd5, 2, bc);
        check_eq("fast rem busy", 64'(bc), 64'd2);
        run_op("fast div ovf", 0, DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 2, bc);
        check_eq("fast div ovf busy", 64'(bc), 64'd2);
        run_op("fast rem ovf", 0, REM, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 2, bc);
        run_op("fast mul zero", 0, MUL, 64'd0, 64'd12345, 64'd0, 2, bc);

        // Back-to-back: second start lands in the done cycle of the first
        run_op("b2b first", 0, MUL, 64'd6, 64'd7, 64'd42, 34, bc);
        run_op("b2b second", 0, REMU, 64'd100, 64'd7, 64'd2, 34, bc);
        run_op("pre-flush", 0, MUL, 64'd6, 64'd7, 64'd42, 34, bc);

        start_op(0, DIVU, 64'd1000, 64'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush to idle", {63'h0, busy32}, 64'h0);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32) cnt++;
        end
        check_eq("flush no done", 64'(cnt), 64'd0);
        check_eq("flush result kept", {32'h0, result32}, 64'd42);

        @(negedge clk);
        start32 = 1'b1;
        flush   = 1'b1;
        funct3  = MUL;
        rs1     = 64'd3;
        rs2     = 64'd4;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        flush   = 1'b0;
        check_eq("start with flush ignored", {63'h0, busy32}, 64'h0);

        start_op(0, MUL, 64'd3, 64'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start32 = 1'b1;
        funct3  = DIVU;
        rs1     = 64'd100;
        rs2     = 64'd7;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        wait_done(0, lat, bc);
        check_eq("start while busy result", {32'h0, result32}, 64'd15);
        check_eq("start while busy latency", 64'(lat + 6), 64'd34);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32) cnt++;
        end
        check_eq("start while busy not queued", 64'(cnt), 64'd0);

        run_op("mulhu64", 1, MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 66, bc);

        start_op(1, MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid reset busy64", {63'h0, busy64}, 64'h0);
        check_eq("mid reset done64", {63'h0, done64}, 64'h0);
        check_eq("mid reset result64", result64, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done64) cnt++;
        end
        check_eq("mid reset no done", 64'(cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
